// File: rtl/fifo_pop_arbiter.sv
// Two-input round-robin pop arbiter between two upstream lane FIFOs and one downstream FIFO,
// with credit-based downstream occupancy tracking. Define FIFO_ARB_STRICT_PRIO_EN for fixed FIFO0 priority.
module fifo_pop_arbiter #(
  parameter int data_width = 6,
  parameter int DOWN_DEPTH = 4,
  parameter int OCC_W      = 3
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  init,
  input  logic                  empty_0,
  input  logic                  empty_1,
  input  logic [data_width-1:0] data_in_0,
  input  logic [data_width-1:0] data_in_1,
  output logic                  pop_0,
  output logic                  pop_1,
  input  logic                  down_rd,
  output logic                  push,
  output logic [data_width-1:0] data_out,
  output logic                  src,
  output logic                  error
);

  logic                  r_prio;
  logic [OCC_W-1:0]      r_occ;
  logic                  r_v1;
  logic                  r_s1;
  logic                  r_push;
  logic [data_width-1:0] r_data_out;
  logic                  r_src;
  logic                  r_error;

  logic                  w_room;
  logic                  w_elig_0;
  logic                  w_elig_1;
  logic                  w_gnt_v;
  logic                  w_gnt_idx;
  logic                  w_ret;
  logic [OCC_W-1:0]      w_occ_nxt;

  // A slot is reserved at pop time, so the credit check covers reads still in flight.
  assign w_room   = (r_occ < OCC_W'(DOWN_DEPTH));
  assign w_elig_0 = !empty_0 && w_room && reset_L && init;
  assign w_elig_1 = !empty_1 && w_room && reset_L && init;
  assign w_ret    = down_rd && (r_occ != '0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_gnt_v   = w_elig_0 || w_elig_1;
    w_gnt_idx = 1'b0;
`ifdef FIFO_ARB_STRICT_PRIO_EN
    w_gnt_idx = !w_elig_0;
`else
    if (w_elig_0 && w_elig_1) w_gnt_idx = r_prio;
    else                      w_gnt_idx = w_elig_1;
`endif
    pop_0 = w_gnt_v && !w_gnt_idx;
    pop_1 = w_gnt_v &&  w_gnt_idx;
  end

  always_comb begin
    w_occ_nxt = r_occ;
    if (w_gnt_v && !w_ret)      w_occ_nxt = r_occ + OCC_W'(1);
    else if (!w_gnt_v && w_ret) w_occ_nxt = r_occ - OCC_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_prio     <= 1'b0;
      r_occ      <= '0;
      r_v1       <= 1'b0;
      r_s1       <= 1'b0;
      r_push     <= 1'b0;
      r_data_out <= '0;
      r_src      <= 1'b0;
      r_error    <= 1'b0;
    end else if (!init) begin
      r_prio     <= 1'b0;
      r_occ      <= '0;
      r_v1       <= 1'b0;
      r_s1       <= 1'b0;
      r_push     <= 1'b0;
      r_data_out <= '0;
      r_src      <= 1'b0;
      r_error    <= 1'b0;
    end else begin
`ifdef FIFO_ARB_STRICT_PRIO_EN
      r_prio <= 1'b0;
`else
      if (w_gnt_v) r_prio <= !w_gnt_idx;
`endif
      r_occ <= w_occ_nxt;
      r_v1  <= w_gnt_v;
      r_s1  <= w_gnt_v && w_gnt_idx;
      // Upstream read data is valid only in the cycle after the pop, so the lane is picked by stage 1.
      r_push     <= r_v1;
      r_src      <= r_s1;
      r_data_out <= r_v1 ? (r_s1 ? data_in_1 : data_in_0) : '0;
      if (down_rd && (r_occ == '0)) r_error <= 1'b1;
    end
  end

  assign push     = r_push;
  assign data_out = r_data_out;
  assign src      = r_src;
  assign error    = r_error;

endmodule

// File: tb/tb_fifo_pop_arbiter.sv
// Self-checking bench for fifo_pop_arbiter: queue-based upstream FIFOs, a transaction-level
// reference model checked every cycle, directed literal scenarios and a randomized run.
module tb_fifo_pop_arbiter;
  localparam int DW    = 6;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_L = 1'b0;
  logic          init = 1'b1;
  logic          empty_0 = 1'b1;
  logic          empty_1 = 1'b1;
  logic [DW-1:0] data_in_0 = '0;
  logic [DW-1:0] data_in_1 = '0;
  logic          down_rd = 1'b0;
  logic          pop_0, pop_1, push, src, error;
  logic [DW-1:0] data_out;

  fifo_pop_arbiter #(.data_width(DW), .DOWN_DEPTH(DEPTH), .OCC_W(3)) dut (
    .clk(clk), .reset_L(reset_L), .init(init),
    .empty_0(empty_0), .empty_1(empty_1),
    .data_in_0(data_in_0), .data_in_1(data_in_1),
    .pop_0(pop_0), .pop_1(pop_1), .down_rd(down_rd),
    .push(push), .data_out(data_out), .src(src), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Upstream FIFO contents (front = next entry to be read).
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  // Reference model: credit count, rotating priority, transactions in flight, sticky error.
  int            m_occ = 0;
  bit            m_prio = 0;
  bit            s1_v = 0, s1_s = 0;
  logic [DW-1:0] s1_d = '0;
  bit            o_v = 0, o_s = 0;
  logic [DW-1:0] o_d = '0;
  bit            m_err = 0;
  int            resident = 0;

  bit            pend0 = 0, pend1 = 0;
  bit            p0, p1;
  logic          h_push, h_src, h_err;
  logic [DW-1:0] h_data;

  // One clock cycle: compare registered outputs, drive inputs, compare pops, advance model.
  task automatic step(input bit drd, input bit ini, input bit rstn);
    bit e0, e1, gv, gs;
    @(posedge clk);
    #1;
    if (pend0 && q0.size() > 0) data_in_0 = q0.pop_front();
    if (pend1 && q1.size() > 0) data_in_1 = q1.pop_front();
    h_push = push; h_data = data_out; h_src = src; h_err = error;
    check("push", push, o_v);
    check("error", error, m_err);
    check("data_out", data_out, o_v ? o_d : '0);
    if (o_v) check("src", src, o_s);

    reset_L = rstn; init = ini; down_rd = drd;
    empty_0 = (q0.size() == 0);
    empty_1 = (q1.size() == 0);
    #1;
    p0 = pop_0; p1 = pop_1;

    e0 = rstn && ini && q0.size() > 0 && m_occ < DEPTH;
    e1 = rstn && ini && q1.size() > 0 && m_occ < DEPTH;
    gv = e0 || e1;
`ifdef FIFO_ARB_STRICT_PRIO_EN
    gs = !e0;
`else
    gs = (e0 && e1) ? m_prio : e1;
`endif
    check("pop_0", p0, gv && !gs);
    check("pop_1", p1, gv && gs);
    pend0 = p0; pend1 = p1;

    if (!rstn || !ini) begin
      m_occ = 0; m_prio = 0; s1_v = 0; s1_s = 0; s1_d = '0;
      o_v = 0; o_s = 0; o_d = '0; m_err = 0; resident = 0;
    end else begin
      if (drd && resident > 0) resident--;
      if (s1_v) resident++;
      o_v = s1_v; o_s = s1_s; o_d = s1_v ? s1_d : '0;
      s1_v = gv; s1_s = gv && gs;
      s1_d = !gv ? '0 : (gs ? q1[0] : q0[0]);
      if (drd && m_occ == 0) m_err = 1;
      m_occ = m_occ + (gv ? 1 : 0) - ((drd && m_occ > 0) ? 1 : 0);
`ifndef FIFO_ARB_STRICT_PRIO_EN
      if (gv) m_prio = !gs;
`endif
    end
  endtask

  logic [1:0]    log_pop [8];
  logic          log_push[8];
  logic [DW-1:0] log_data[8];
  logic          log_src [8];
  logic [1:0]    exp_pop [6];
  logic [DW-1:0] exp_data[4];
  logic          exp_src [4];
  int            cnt;

  initial begin
    // Reset with both upstream FIFOs non-empty: no pops, outputs cleared.
    q0.push_back(6'h01); q1.push_back(6'h02);
    step(0, 1, 0);
    step(0, 1, 0);
    check("rst_pop_0", p0, 1'b0);
    check("rst_pop_1", p1, 1'b0);
    check("rst_push", push, 1'b0);
    check("rst_data", data_out, '0);
    check("rst_src", src, 1'b0);
    check("rst_err", error, 1'b0);
    q0.delete(); q1.delete();

    // Round-robin: FIFO0 {11,12}, FIFO1 {21,22}, no credit returns.
    q0.push_back(6'h11); q0.push_back(6'h12);
    q1.push_back(6'h21); q1.push_back(6'h22);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 1);
      log_pop[i] = {p1, p0}; log_push[i] = h_push; log_data[i] = h_data; log_src[i] = h_src;
    end
`ifdef FIFO_ARB_STRICT_PRIO_EN
    exp_pop  = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00};
    exp_data = '{6'h11, 6'h12, 6'h21, 6'h22};
    exp_src  = '{1'b0, 1'b0, 1'b1, 1'b1};
`else
    exp_pop  = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
    exp_data = '{6'h11, 6'h21, 6'h12, 6'h22};
    exp_src  = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    for (int i = 0; i < 6; i++) check("rr_pop_seq", log_pop[i], exp_pop[i]);
    check("rr_no_push_c0", log_push[0], 1'b0);
    check("rr_no_push_c1", log_push[1], 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("rr_push", log_push[i+2], 1'b1);
      check("rr_data", log_data[i+2], exp_data[i]);
      check("rr_src", log_src[i+2], exp_src[i]);
    end

    // Downstream full (4 credits used): nothing popped despite data waiting.
    q0.push_back(6'h13); q1.push_back(6'h23);
    step(0, 1, 1);
    check("full_no_pop", {p1, p0}, 2'b00);
    // Credit return at occ=4: no pop this cycle, exactly one pop next cycle.
    step(1, 1, 1);
    check("ret_no_pop", {p1, p0}, 2'b00);
    step(0, 1, 1);
    check("ret_one_pop", {p1, p0}, 2'b01);
    step(0, 1, 1);
    check("refull_no_pop", {p1, p0}, 2'b00);
    // Grant and credit return in the same cycle keep occ at 3, leaving room for one more pop.
    q0.push_back(6'h14); q0.push_back(6'h15);
    step(1, 1, 1);
    check("ret2_no_pop", {p1, p0}, 2'b00);
    step(1, 1, 1);
    check("simul_pop", 32'(p0) + 32'(p1), 32'd1);
    step(0, 1, 1);
    check("occ3_pop", 32'(p0) + 32'(p1), 32'd1);
    step(0, 1, 1);
    check("occ4_no_pop", {p1, p0}, 2'b00);

    // Soft clear for one edge: no pops while low, everything cleared afterwards.
    step(0, 0, 1);
    check("init_pop", {p1, p0}, 2'b00);
    step(0, 1, 1);
    check("init_push", h_push, 1'b0);
    check("init_data", h_data, '0);
    check("init_err", h_err, 1'b0);

    // Single source: only FIFO1 with three entries.
    step(0, 1, 0);
    q0.delete(); q1.delete();
    q1.push_back(6'h31); q1.push_back(6'h32); q1.push_back(6'h33);
    for (int i = 0; i < 7; i++) begin
      step(0, 1, 1);
      log_pop[i] = {p1, p0}; log_push[i] = h_push; log_data[i] = h_data; log_src[i] = h_src;
    end
    for (int i = 0; i < 6; i++) check("single_pop", log_pop[i], (i < 3) ? 2'b10 : 2'b00);
    cnt = 0;
    for (int i = 0; i < 7; i++) if (log_push[i] && log_src[i]) cnt++;
    check("single_pushes", cnt, 3);
    check("single_data_first", log_data[2], 6'h31);
    check("single_data_last", log_data[4], 6'h33);

    // Error: credit return with occ=0 sets a sticky error, cleared only by init/reset.
    step(0, 1, 0);
    q0.delete(); q1.delete();
    step(1, 1, 1);
    step(0, 1, 1);
    check("err_set", h_err, 1'b1);
    for (int i = 0; i < 3; i++) step(0, 1, 1);
    check("err_sticky", h_err, 1'b1);
    step(0, 0, 1);
    step(0, 1, 1);
    check("err_cleared", h_err, 1'b0);

    // Randomized traffic with occasional soft clears and asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      bit drd, ini, rstn;
      if (q0.size() < 6 && $urandom_range(0, 2) != 0) q0.push_back(DW'($urandom));
      if (q1.size() < 6 && $urandom_range(0, 2) != 0) q1.push_back(DW'($urandom));
      drd  = (resident > 0) && ($urandom_range(0, 2) == 0);
      ini  = ($urandom_range(0, 199) != 0);
      rstn = ($urandom_range(0, 499) != 0);
      step(drd, ini, rstn);
    end
    step(0, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fifo_pop_arbiter.md
# fifo_pop_arbiter

Two-input round-robin read arbiter placed between a pair of upstream lane FIFOs (D0/D1 type, registered read data one cycle after `rd_enable`) and a single downstream FIFO. It pops whichever upstream FIFO is eligible, re-aligns the returned data, and pushes it downstream. A credit counter tracks downstream occupancy so the downstream FIFO can never overflow, even with reads in flight.

## Interface
- `data_width`, 6, payload width
- `DOWN_DEPTH`, 4, downstream FIFO depth in entries
- `OCC_W`, 3, occupancy counter width; must hold 0..`DOWN_DEPTH`

- `clk`  in  1  rising-edge clock
- `reset_L`  in  1  reset; asynchronous, active-low
- `init`  in  1  synchronous soft clear, active-low; same effect as reset at the next edge
- `empty_0`, `empty_1`  in  1  upstream FIFO empty flags
- `data_in_0`, `data_in_1`  in  `data_width`  upstream registered read data
- `pop_0`, `pop_1`  out  1  combinational read enables to the upstream FIFOs
- `down_rd`  in  1  downstream FIFO popped this cycle (its `rd_enable`)
- `push`  out  1  registered write enable to the downstream FIFO
- `data_out`  out  `data_width`  registered write data
- `src`  out  1  registered source of `data_out`: 0 = FIFO0, 1 = FIFO1
- `error`  out  1  sticky; `down_rd` was seen while `occ` = 0

## Operation
- **State:** `prio` (1 bit); `occ` (`OCC_W`, reserved plus resident downstream entries); stage-1 `v1`/`s1`; output regs `push`/`data_out`/`src`; `error`.
- **Eligibility:** FIFO k is eligible when `empty_k` = 0, `occ` < `DOWN_DEPTH`, and `reset_L` = `init` = 1.
- **Grant:** at most one pop per cycle.
  - Both eligible: grant `prio`.
  - One eligible: grant that one.
  - After a grant to k, `prio` becomes ~k.
  - No grant: `prio` holds.
- **Occupancy:** `occ` <= `occ` + grant − (`down_rd` and `occ` > 0).
  - Grant and `down_rd` in the same cycle leave `occ` unchanged.
  - `down_rd` with `occ` = 0 is ignored for counting and sets `error`.
- **Stage 1:** `v1` <= grant, `s1` <= granted index.
- **Output stage:** `push` <= `v1`; `src` <= `s1`; `data_out` <= `data_in_s1` when `v1` = 1, else 0.
- **Reset:** `reset_L` = 0 asynchronously clears `prio`, `occ`, `v1`, `s1`, `push`, `data_out`, `src` and `error` to 0.
  - `init` = 0 clears the same registers at the next edge.
  - `pop_0` and `pop_1` are forced to 0 while either is low.
- **Reset mid-operation:** in-flight entries are discarded. The downstream FIFO is reset or initialised together with this block.

## Timing
- `pop_k` is combinational from current flags and state. A pop in cycle N is consumed by the upstream FIFO at the end of N.
- Upstream data is valid during N+1; `push`/`data_out`/`src` are valid during N+2. Pop-to-push latency is 2 cycles.
- Throughput is 1 entry per cycle, including back-to-back pops of the same FIFO. No bubble is inserted because the empty flags update at the same edge as the pop.
- `occ` reserves a slot at pop time, so up to 2 in-flight entries are always covered.
- The first pop is possible in the first cycle after `reset_L` and `init` are both high.
- Counter width: `occ` never exceeds `DOWN_DEPTH` and never wraps below 0.

## Configuration
- Macro: `FIFO_ARB_STRICT_PRIO_EN`.
- Defined: FIFO0 always wins when both are eligible; FIFO1 is granted only when FIFO0 is not eligible. `prio` is unused and held at 0.
- Undefined: round-robin as in Operation.
- Ports and latency are identical in both builds.

## Test plan
- **Reset:** `reset_L` = 0 with `empty_0` = `empty_1` = 0 -> `pop_0` = `pop_1` = 0. `push`, `data_out`, `src` and `error` are 0. Same result holding `init` = 0 for one edge.
- **Round-robin:** both non-empty (FIFO0: 0x11, 0x12; FIFO1: 0x21, 0x22), `DOWN_DEPTH` = 4, `down_rd` = 0 -> pops 0,1,0,1 in cycles 0–3, then none. `push` high in cycles 2–5 with `data_out` 0x11, 0x21, 0x12, 0x22 and `src` 0,1,0,1. `occ` = 4.
- **Single source:** only FIFO1 non-empty with 3 entries -> `pop_1` high for 3 consecutive cycles, then low once `empty_1` rises. 3 pushes with `src` = 1.
- **Credit return:** with `occ` = 4, pulse `down_rd` -> `occ` = 3 and exactly one pop next cycle. With `occ` = 3, grant and `down_rd` in the same cycle -> `occ` stays 3.
- **Error:** with `occ` = 0, assert `down_rd` -> `error` = 1 from the next cycle and held until reset or `init`.
- **Strict priority (`FIFO_ARB_STRICT_PRIO_EN` defined):** both non-empty with 2 entries each -> `pop_0` in cycles 0–1, `pop_1` in cycles 2–3.
